// File: rtl/ram_sp_pkg.sv
// Shared constants and state encoding for the single-port RAM responder.
package ram_sp_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sp_array.sv
// Plain storage: one write port, one synchronous write-first read port, no reset.
module ram_sp_array
    import ram_sp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rd_en gates the output register so clear-phase writes leave rd_data untouched
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= we ? wr_data : mem[addr];
        end
    end

endmodule

// File: rtl/ram_sp_responder.sv
// Memory-side responder for the ram_rw port: hardware clear after reset, ready flag,
// read-valid strobe. Define RAM_OUT_REG_EN to add an output register (2-cycle latency).
module ram_sp_responder
    import ram_sp_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    output logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rd_valid,
    output logic              ram_ready
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_addr;

    logic              arr_we;
    logic              arr_rd_en;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wr_data;
    logic [DATA_W-1:0] arr_rd_data;

    logic              rd_valid_p1;
    logic              data_seen_p1;
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (clr_addr == '1) next_state = ST_RUN;
            ST_RUN:   next_state = ST_RUN;
            default:  next_state = ST_CLEAR;
        endcase
    end

    // Write-port mux: the clear sweep owns the array until RUN, user accesses after
    always_comb begin
        arr_we      = 1'b0;
        arr_rd_en   = 1'b0;
        arr_addr    = ram_addr;
        arr_wr_data = ram_wr_data;
        case (state)
            ST_CLEAR: begin
                arr_we      = 1'b1;
                arr_addr    = clr_addr;
                arr_wr_data = INIT_VAL;
            end
            ST_RUN: begin
                arr_we    = ram_en & ram_we;
                arr_rd_en = ram_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ready <= 1'b0;
        end else begin
            ram_ready <= (next_state == ST_RUN);
        end
    end

    ram_sp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .rd_en   (arr_rd_en),
        .addr    (arr_addr),
        .wr_data (arr_wr_data),
        .rd_data (arr_rd_data)
    );

    // ---- stage p1: array output, valid strobe ----
    // The array register has no reset; data_seen masks it to 0 until the first access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_p1  <= 1'b0;
            data_seen_p1 <= 1'b0;
        end else begin
            rd_valid_p1 <= (state == ST_RUN) && ram_en && !ram_we;
            if ((state == ST_RUN) && ram_en) begin
                data_seen_p1 <= 1'b1;
            end
        end
    end

    assign rd_data_p1 = data_seen_p1 ? arr_rd_data : '0;

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] rd_data_p2;
    logic              rd_valid_p2;

    // ---- stage p2: optional output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p2  <= '0;
            rd_valid_p2 <= 1'b0;
        end else begin
            rd_data_p2  <= rd_data_p1;
            rd_valid_p2 <= rd_valid_p1;
        end
    end

    assign ram_rd_data  = rd_data_p2;
    assign ram_rd_valid = rd_valid_p2;
`else
    assign ram_rd_data  = rd_data_p1;
    assign ram_rd_valid = rd_valid_p1;
`endif

endmodule

// File: tb/tb_ram_sp_responder.sv
// Self-checking bench for ram_sp_responder: constant vector table plus a cycle-level reference model.
module tb_ram_sp_responder;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_rd_valid;
    logic              ram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_s1_d, m_out_d;
    logic              m_s1_v, m_out_v;
    int                m_cyc;

    typedef struct {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp_d;
        logic              exp_v;
    } vec_t;

    vec_t tbl [12];

    ram_sp_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_valid (ram_rd_valid),
        .ram_ready    (ram_ready)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] ed,
                                input logic ev);
        vec_t v;
        v.en = en; v.we = we; v.addr = a; v.wd = wd; v.exp_d = ed; v.exp_v = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_s1_d = '0; m_s1_v = 1'b0;
        m_out_d = '0; m_out_v = 1'b0;
        m_cyc = 0;
    endtask

    // One clock: present an access, advance the model, compare all outputs after the edge
    task automatic step(input logic en, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] nd;
        logic              nv;
        ram_en = en; ram_we = we; ram_addr = a; ram_wr_data = wd;
        @(posedge clk);
        nd = m_s1_d;
        nv = 1'b0;
        if (m_cyc >= DEPTH && en) begin
            if (we) begin
                m_mem[a] = wd;
                nd = wd;
            end else begin
                nd = m_mem[a];
                nv = 1'b1;
            end
        end
        m_out_d = (LAT == 2) ? m_s1_d : nd;
        m_out_v = (LAT == 2) ? m_s1_v : nv;
        m_s1_d = nd;
        m_s1_v = nv;
        m_cyc++;
        #1;
        check("rd_data", 32'(ram_rd_data), 32'(m_out_d));
        check("rd_valid", 32'(ram_rd_valid), 32'(m_out_v));
        check("ready", 32'(ram_ready), 32'(m_cyc >= DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic read_all_zero();
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 1'b0, ADDR_W'(k), '0);
            if (LAT == 1) check("clear_read", 32'(ram_rd_data), 32'h0);
        end
        idle(LAT);
    endtask

    initial begin
        logic              r_en, r_we;
        logic [ADDR_W-1:0] r_a;
        logic [DATA_W-1:0] r_d;
        int                k;

        tbl[0]  = mk(1'b1, 1'b1, 5'd5, 8'hA5, 8'hA5, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1);
        tbl[2]  = mk(1'b1, 1'b1, 5'd3, 8'h3C, 8'h3C, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 5'd3, 8'h00, 8'h3C, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 5'd9, 8'hFF, 8'h3C, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 5'd3, 8'hEE, 8'h3C, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0, 8'h00, 8'h3C, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 5'd1, 8'h11, 8'h3C, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 5'd7, 8'h11, 8'h11, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 5'd7, 8'h00, 8'h11, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 5'd7, 8'h00, 8'h11, 1'b1);

        rst = 1'b1; ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", 32'(ram_rd_data), 32'h0);
        check("reset_rd_valid", 32'(ram_rd_valid), 32'h0);
        check("reset_ready", 32'(ram_ready), 32'h0);
        rst = 1'b0;

        // clear phase; a write to addr 3 at cycle 10 must be dropped
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 10) step(1'b1, 1'b1, 5'd3, 8'h77);
            else         step(1'b0, 1'b0, '0, '0);
            if (i == DEPTH - 1) check("ready_before_32", 32'(ram_ready), 32'h0);
        end
        check("ready_at_32", 32'(ram_ready), 32'h1);
        read_all_zero();

        // fixed vectors, output compared LAT-1 cycles after each access
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wd);
            if (i >= LAT - 1) begin
                check("tbl_data", 32'(ram_rd_data), 32'(tbl[i - LAT + 1].exp_d));
                check("tbl_valid", 32'(ram_rd_valid), 32'(tbl[i - LAT + 1].exp_v));
            end
        end
        for (int j = 0; j < LAT - 1; j++) begin
            step(1'b0, 1'b0, '0, '0);
            check("tbl_data_tail", 32'(ram_rd_data), 32'(tbl[12 - LAT + 1 + j].exp_d));
            check("tbl_valid_tail", 32'(ram_rd_valid), 32'(tbl[12 - LAT + 1 + j].exp_v));
        end

        // ram_rw-style fill and readback; data k appears LAT cycles after address k
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i));
        for (int i = 0; i < DEPTH + LAT; i++) begin
            if (i < DEPTH) step(1'b1, 1'b0, ADDR_W'(i), '0);
            else           step(1'b0, 1'b0, '0, '0);
            if (i >= LAT - 1 && i - LAT + 1 < DEPTH) begin
                check("seq_read", 32'(ram_rd_data), 32'(i - LAT + 1));
                check("seq_valid", 32'(ram_rd_valid), 32'h1);
            end
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_we = 1'($urandom_range(0, 1));
            r_a  = ADDR_W'($urandom_range(0, DEPTH - 1));
            r_d  = DATA_W'($urandom_range(0, 255));
            step(r_en, r_we, r_a, r_d);
        end

        // fill, then reset in the middle of a read burst
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, ADDR_W'(i), ~DATA_W'(i));
        k = 0;
        while (k < 10) begin
            step(1'b1, 1'b0, ADDR_W'(k), '0);
            k++;
        end
        rst = 1'b1;
        #1;
        check("midrst_rd_data", 32'(ram_rd_data), 32'h0);
        check("midrst_rd_valid", 32'(ram_rd_valid), 32'h0);
        check("midrst_ready", 32'(ram_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, ADDR_W'(i), '0);
        check("ready_after_rst", 32'(ram_ready), 32'h1);
        read_all_zero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sp_responder.md
# ram_sp_responder

Synthesizable single-port RAM responder: the memory-side end of the `ram_en`/`ram_we`/`ram_addr`/`ram_wr_data`/`ram_rd_data` port driven by the `ram_rw` initiator. It lets that initiator run without the vendor block-memory IP in simulation or on portable targets. It adds three things on top of plain storage: hardware clear after reset, a ready flag, and a read-valid strobe. It sits beside `ram_rw` under the top level, one instance per port.

## Interface
Parameters:
- `ADDR_W`, 5: address width; depth = 2^ADDR_W words.
- `DATA_W`, 8: data width.
- `INIT_VAL`, 0: word written to every location during the clear phase.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ram_en`  in  1: access enable.
- `ram_we`  in  1: write enable; meaningful only with `ram_en`.
- `ram_addr`  in  ADDR_W: word address.
- `ram_wr_data`  in  DATA_W: write data.
- `ram_rd_data`  out  DATA_W: read data (write-first on writes).
- `ram_rd_valid`  out  1: one-cycle strobe marking `ram_rd_data` as the result of a read.
- `ram_ready`  out  1: high once the clear phase is complete and accesses are accepted.

## Operation
- State machine with two states: CLEAR and RUN.
- Reset forces CLEAR and clears the clear-address counter to 0.
- CLEAR behaviour:
  - Each cycle writes `INIT_VAL` to the counter address, then increments the counter.
  - When the counter reaches 2^ADDR_W−1 and that location is written, the next state is RUN.
  - The block ignores `ram_en`, `ram_we`, `ram_addr` and `ram_wr_data` in CLEAR: no write, no `ram_rd_valid`, and `ram_rd_data` holds.
- RUN: accesses are decoded as follows.
  - `ram_en`=1, `ram_we`=0 (read): `ram_rd_data` ← mem[addr]; `ram_rd_valid` pulses.
  - `ram_en`=1, `ram_we`=1 (write): mem[addr] ← `ram_wr_data`; `ram_rd_data` ← `ram_wr_data` (write-first); `ram_rd_valid` stays 0.
  - `ram_en`=0: no access; `ram_rd_data` holds its last value; `ram_rd_valid` is 0.
- Back-to-back accesses are allowed every cycle, with no stalls or back-pressure in RUN.
- A read of the address written in the previous cycle returns the new data.
- `ram_ready` = (state == RUN), registered.
- Reset mid-operation: outputs reset immediately (asynchronous), the state returns to CLEAR, and the clear restarts from address 0. Memory contents before the clear completes are not guaranteed.

## Timing
- Output reset values: `ram_rd_data`=0, `ram_rd_valid`=0, `ram_ready`=0.
- Clear duration: exactly 2^ADDR_W cycles after the first rising edge with `rst` low; `ram_ready` rises on edge 2^ADDR_W (edge 32 with default parameters).
- The first access is accepted on the first edge where `ram_ready`=1 was presented before that edge. Accesses presented while `ram_ready`=0 are dropped; the initiator must wait for `ram_ready`.
- Read latency: 1 cycle. An access sampled at edge N drives `ram_rd_data` and `ram_rd_valid` after edge N.
- `ram_rd_valid` is high for exactly one cycle per read; consecutive reads give a continuous high.

## Configuration
- `RAM_OUT_REG_EN` defined: adds an output register stage.
  - Read latency becomes 2 cycles.
  - `ram_rd_valid` is delayed by the same stage so it stays aligned with the data.
  - The output register resets to 0.
  - `ram_ready` timing is unchanged.
- `RAM_OUT_REG_EN` undefined: 1-cycle latency as described above.

## Structure
- Shared package `ram_sp_pkg` holds:
  - default `ADDR_W` and `DATA_W` constants;
  - the state encoding typedef (`ST_CLEAR`, `ST_RUN`).
- Sub-module `ram_sp_array` holds the plain storage array: one write port, one synchronous read port, write-first, no reset, inferable as block RAM.
- `ram_sp_responder` owns the FSM, the clear counter, the write-port mux between clear and user access, the valid pipeline and the optional output register.

## Test plan
- Reset, then 32 idle cycles: `ram_ready`=0 until edge 32, then 1; read every address 0..31 → all return 0x00, each with a `ram_rd_valid` pulse.
- `ram_rw`-style sequence: write addr k ← k for k=0..31, then read 0..31 → data 0..31 in order, one cycle after each address (two with `RAM_OUT_REG_EN`).
- Write addr 5 ← 0xA5 with `ram_we`=1 → `ram_rd_data`=0xA5 next cycle, `ram_rd_valid`=0; immediate read of addr 5 → 0xA5 with `ram_rd_valid`=1.
- Write addr 3 ← 0x77 during CLEAR at cycle 10 → ignored; after ready, read addr 3 → 0x00.
- After filling memory, assert `rst` mid-burst for 1 cycle → outputs 0 at once, `ram_ready` low for 32 cycles, then all addresses read 0x00.
- `ram_en`=0 for 4 cycles after a read of 0x3C → `ram_rd_data` holds 0x3C and `ram_rd_valid` stays 0.
